elevator_scan_ctrl: RTL

- Parametrised successor to the 4-floor up/down elevator_controller.
- Serves NUM_FLOORS floors with latched per-floor call requests, a SCAN (elevator-algorithm) scheduler, a multi-cycle travel timer and a door-open timer.
- Sits between the call-button capture logic and the floor display/motor drive; the display consumes `floor` directly.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/elevator_req_scan.sv | 35 +++
 rtl/elevator_scan_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default timing for the SCAN elevator controller.
//   state_t            : FSM encoding (IDLE / MOVE / DOOR), 2 bits
//   DEF_TRAVEL_CYCLES  : default clocks to move one floor
//   DEF_DOOR_CYCLES    : default clocks the door stays open per stop
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int DEF_NUM_FLOORS    = 4;
  localparam int DEF_TRAVEL_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES   = 8;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scanner.
//   pending  : latched, unserviced per-floor requests
//   floor    : current car floor
//   dir_up   : current/last scan direction
//   here     : request pending at the current floor
//   above    : any request above the current floor
//   below    : any request below the current floor
//   next_dir : direction SCAN would take from here (keeps dir_up if idle)
module elevator_req_scan #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  dir_up,
  output logic                  here,
  output logic                  above,
  output logic                  below,
  output logic                  next_dir
);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(floor))) above = 1'b1;
      if (pending[i] && (i < int'(floor))) below = 1'b1;
    end
    here = pending[floor];
    // Keep going the way we were while work remains ahead; only turn
    // around when everything left is behind the car.
    next_dir = dir_up ? (above | ~below) : (above & ~below);
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator controller for NUM_FLOORS floors.
//   clk, reset : clock (rising edge), async active-high reset
//   call_req   : per-floor calls, OR-latched into pending every edge
//   floor      : current floor index (drives the display)
//   dir_up     : current/last scan direction (1 = up)
//   moving     : car travelling between floors
//   door_open  : door open at floor
//   arrive     : one-cycle pulse when the car stops at a floor from MOVE
//   pending    : latched, unserviced requests
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TCW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DCW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TCW-1:0]     T_LOAD    = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]     D_LOAD    = DCW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state, state_n;
  logic [FLOOR_W-1:0]      floor_n;
  logic                    dir_n, arrive_n;
  logic [TCW-1:0]          tcnt, tcnt_n;
  logic [DCW-1:0]          dcnt, dcnt_n;
  logic [NUM_FLOORS-1:0]   clr_mask;
  logic                    here, above, below, next_dir;

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .pending  (pending),
    .floor    (floor),
    .dir_up   (dir_up),
    .here     (here),
    .above    (above),
    .below    (below),
    .next_dir (next_dir)
  );

  always_comb begin
    state_n  = state;
    floor_n  = floor;
    dir_n    = dir_up;
    tcnt_n   = tcnt;
    dcnt_n   = dcnt;
    arrive_n = 1'b0;
    clr_mask = '0;
    unique case (state)
      IDLE: begin
        if (here) begin
          state_n         = DOOR;
          dcnt_n          = D_LOAD;
          clr_mask[floor] = 1'b1;
        end else if (above || below) begin
          state_n = MOVE;
          dir_n   = next_dir;
          tcnt_n  = T_LOAD;
        end
      end
      MOVE: begin
        if (tcnt == '0) begin
          floor_n = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
          // Stop decision uses registered pending at the new floor; a call
          // latched for the floor just left waits for a later pass.
          if (pending[floor_n]) begin
            state_n           = DOOR;
            arrive_n          = 1'b1;
            dcnt_n            = D_LOAD;
            clr_mask[floor_n] = 1'b1;
          end else begin
            tcnt_n = T_LOAD;
          end
        end else begin
          tcnt_n = tcnt - TCW'(1);
        end
      end
      DOOR: begin
        if (call_req[floor]) begin
          // Re-press at this floor holds the door and is consumed here.
          dcnt_n          = D_LOAD;
          clr_mask[floor] = 1'b1;
        end else if (dcnt == '0) begin
          if (above || below) begin
            state_n = MOVE;
            dir_n   = next_dir;
            tcnt_n  = T_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          dcnt_n = dcnt - DCW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      floor   <= '0;
      dir_up  <= 1'b1;
      arrive  <= 1'b0;
      pending <= '0;
      tcnt    <= '0;
      dcnt    <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir_up  <= dir_n;
      arrive  <= arrive_n;
      pending <= (pending | call_req) & ~clr_mask;
      tcnt    <= tcnt_n;
      dcnt    <= dcnt_n;
    end
  end

  assign moving    = (state == MOVE);
  assign door_open = (state == DOOR);

  // The scheduler only heads toward pending floors, so a step past either
  // end of the shaft means the scan logic is broken.
  a_floor_range: assert property (@(posedge clk) disable iff (reset)
    floor <= TOP_FLOOR);
  a_no_wrap: assert property (@(posedge clk) disable iff (reset)
    (state == MOVE && tcnt == '0) |-> (dir_up ? (floor != TOP_FLOOR) : (floor != '0)));

endmodule
